execute_stage: RTL

//  EX stage of the 5-stage RV32 pipeline, between the ID/EX register and the MEM stage.

---
 rtl/execute_stage.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32 pipeline: operand forwarding, ALU, branch compare,
// PC+imm adder, an iterative shift-add multiplier that stalls upstream, and the
// EX/MEM pipeline register.
module execute_stage #(
    parameter int unsigned XLEN   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_in,
    input  logic            Ctl_MemtoReg_in,
    input  logic            Ctl_RegWrite_in,
    input  logic            Ctl_MemRead_in,
    input  logic            Ctl_MemWrite_in,
    input  logic            Ctl_Branch_in,
    input  logic            Ctl_ALUSrc_in,
    input  logic [1:0]      Ctl_ALUOp_in,
    input  logic            jal_in,
    input  logic            jalr_in,
    input  logic [2:0]      funct3_in,
    input  logic [6:0]      funct7_in,
    input  logic [4:0]      Rd_in,
    input  logic [XLEN-1:0] ReadData1_in,
    input  logic [XLEN-1:0] ReadData2_in,
    input  logic [XLEN-1:0] Imm_in,
    input  logic [XLEN-1:0] PC_in,
    input  logic [1:0]      ForwardA_in,
    input  logic [1:0]      ForwardB_in,
    input  logic [XLEN-1:0] Fwd_Mem_in,
    input  logic [XLEN-1:0] Fwd_WB_in,
    output logic            stall_out,
    output logic            Ctl_MemtoReg_out,
    output logic            Ctl_RegWrite_out,
    output logic            Ctl_MemRead_out,
    output logic            Ctl_MemWrite_out,
    output logic            Ctl_Branch_out,
    output logic            jal_out,
    output logic            jalr_out,
    output logic [4:0]      Rd_out,
    output logic            Zero_out,
    output logic [XLEN-1:0] ALUresult_out,
    output logic [XLEN-1:0] Write_Data_out,
    output logic [XLEN-1:0] PCimm_out,
    output logic [XLEN-1:0] PC_out
);

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;

    logic              memtoreg_q, memtoreg_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              branch_q, branch_d;
    logic              jal_q, jal_d;
    logic              jalr_q, jalr_d;
    logic [4:0]        rd_q, rd_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [XLEN-1:0]   pcimm_q, pcimm_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    logic [XLEN-1:0]   op_a, b_fwd, op_b;
    logic [XLEN-1:0]   alu_result;
    logic              branch_taken;
    logic              is_mul;
    logic              stall;
    logic              capture_product;
    logic              bubble;

    // Forwarding muxes and ALU operand B selection
    always_comb begin
        case (ForwardA_in)
            2'b10:   op_a = Fwd_Mem_in;
            2'b01:   op_a = Fwd_WB_in;
            default: op_a = ReadData1_in;
        endcase
        case (ForwardB_in)
            2'b10:   b_fwd = Fwd_Mem_in;
            2'b01:   b_fwd = Fwd_WB_in;
            default: b_fwd = ReadData2_in;
        endcase
        op_b = Ctl_ALUSrc_in ? Imm_in : b_fwd;
        is_mul = MUL_EN && (Ctl_ALUOp_in == 2'b10) && !Ctl_ALUSrc_in &&
                 (funct7_in == 7'b0000001) && (funct3_in == 3'b000) &&
                 !jal_in && !jalr_in;
    end

    // ALU and branch comparator
    always_comb begin
        logic [XLEN-1:0] sum, diff;
        logic [4:0]      shamt;
        logic            lt_s, lt_u;
        sum   = op_a + op_b;
        diff  = op_a - op_b;
        shamt = op_b[4:0];
        lt_s  = $signed(op_a) < $signed(op_b);
        lt_u  = op_a < op_b;
        alu_result = sum;
        if (!(jal_in || jalr_in)) begin
            case (Ctl_ALUOp_in)
                2'b01: alu_result = diff;
                2'b10: begin
                    case (funct3_in)
                        3'b000:  alu_result = (funct7_in[5] && !Ctl_ALUSrc_in) ? diff : sum;
                        3'b001:  alu_result = op_a << shamt;
                        3'b010:  alu_result = XLEN'(lt_s);
                        3'b011:  alu_result = XLEN'(lt_u);
                        3'b100:  alu_result = op_a ^ op_b;
                        3'b101:  alu_result = funct7_in[5] ? XLEN'($signed(op_a) >>> shamt)
                                                            : (op_a >> shamt);
                        3'b110:  alu_result = op_a | op_b;
                        default: alu_result = op_a & op_b;
                    endcase
                end
                default: alu_result = sum;
            endcase
        end
        case (funct3_in)
            3'b000:  branch_taken = (op_a == op_b);
            3'b001:  branch_taken = (op_a != op_b);
            3'b100:  branch_taken = lt_s;
            3'b101:  branch_taken = !lt_s;
            3'b110:  branch_taken = lt_u;
            3'b111:  branch_taken = !lt_u;
            default: branch_taken = 1'b0;
        endcase
    end

    // Multiplier sequencing: operands latched on start, one shift-add step per BUSY cycle
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        acc_d           = acc_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        stall           = 1'b0;
        capture_product = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul && !flush_in) begin
                    stall    = 1'b1;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    count_d  = '0;
                    acc_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (count_q == CW'(XLEN - 1)) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d         = IDLE;
                capture_product = !flush_in;
            end
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM next values; control fields are zeroed for a bubble
    always_comb begin
        bubble       = stall || flush_in;
        alu_result_d = capture_product ? acc_q : alu_result;
        write_data_d = b_fwd;
        pcimm_d      = PC_in + Imm_in;
        pc_d         = PC_in;
        rd_d         = Rd_in;
        memtoreg_d   = Ctl_MemtoReg_in && !bubble;
        regwrite_d   = Ctl_RegWrite_in && !bubble;
        memread_d    = Ctl_MemRead_in  && !bubble;
        memwrite_d   = Ctl_MemWrite_in && !bubble;
        branch_d     = Ctl_Branch_in   && !bubble;
        jal_d        = jal_in          && !bubble;
        jalr_d       = jalr_in         && !bubble;
        if (bubble) begin
            zero_d = 1'b0;
        end else if (Ctl_ALUOp_in == 2'b01) begin
            zero_d = branch_taken;
        end else begin
            zero_d = (alu_result_d == '0);
        end
    end

    // FSM, multiplier state and EX/MEM register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            branch_q     <= 1'b0;
            jal_q        <= 1'b0;
            jalr_q       <= 1'b0;
            rd_q         <= '0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pcimm_q      <= '0;
            pc_q         <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            branch_q     <= branch_d;
            jal_q        <= jal_d;
            jalr_q       <= jalr_d;
            rd_q         <= rd_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pcimm_q      <= pcimm_d;
            pc_q         <= pc_d;
        end
    end

    assign stall_out        = stall;
    assign Ctl_MemtoReg_out = memtoreg_q;
    assign Ctl_RegWrite_out = regwrite_q;
    assign Ctl_MemRead_out  = memread_q;
    assign Ctl_MemWrite_out = memwrite_q;
    assign Ctl_Branch_out   = branch_q;
    assign jal_out          = jal_q;
    assign jalr_out         = jalr_q;
    assign Rd_out           = rd_q;
    assign Zero_out         = zero_q;
    assign ALUresult_out    = alu_result_q;
    assign Write_Data_out   = write_data_q;
    assign PCimm_out        = pcimm_q;
    assign PC_out           = pc_q;

endmodule
